// File: rtl/biquad_sequencer.sv
// Control and arithmetic core of a second-order IIR (biquad) section.
// Each sample runs a fixed 7-cycle schedule. The schedule drives the external
// selector mux, multiply-accumulates the operands it returns, saturates f[k] and
// y[k], and shifts the f[k-1]/f[k-2] delay line.
module biquad_sequencer #(
    parameter int N = 16,
    parameter int F = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] muxS,
    input  logic [N-1:0] muxC,
    input  logic [N-1:0] muxZ,
    output logic [2:0]   controlS,
    output logic [1:0]   controlC,
    output logic [1:0]   controlZ,
    output logic [N-1:0] fk,
    output logic [N-1:0] fk1,
    output logic [N-1:0] fk2,
    output logic [N-1:0] yk,
    output logic         busy,
    output logic         done,
    output logic         sat
);

    localparam int AW = 2 * N + 2;  // accumulator width
    localparam int PW = 2 * N;      // full product width

    typedef enum logic [2:0] {
        StIdle, StF1, StF2, StFs, StY1, StY2, StY3, StOut
    } state_e;

    state_e               state_q, state_d;
    logic signed [AW-1:0] acc_q;
    logic [N-1:0]         fk_q, fk1_q, fk2_q, yk_q;
    logic                 done_q, sat_q;
    logic                 sat_flag_q;  // sticky clamp flag for the sample in flight

    logic                 load;
    logic                 acc_en;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] preload;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] shifted;
    logic [AW-N:0]        shifted_top;
    logic                 clamp;
    logic [N-1:0]         res;

    // Next-state and select decode; selects are zero outside the MAC states
    always_comb begin
        state_d  = state_q;
        controlS = 3'd0;
        controlC = 2'd0;
        controlZ = 2'd0;
        load     = 1'b0;
        acc_en   = 1'b0;
        unique case (state_q)
            StIdle: if (start) state_d = StF1;
            StF1: begin
                controlS = 3'd1; controlC = 2'd1; controlZ = 2'd1;
                load = 1'b1; acc_en = 1'b1; state_d = StF2;
            end
            StF2: begin
                controlS = 3'd2; controlC = 2'd2;
                acc_en = 1'b1; state_d = StFs;
            end
            StFs: state_d = StY1;
            StY1: begin
                controlS = 3'd3; controlC = 2'd3;
                load = 1'b1; acc_en = 1'b1; state_d = StY2;
            end
            StY2: begin
                controlS = 3'd4; controlC = 2'd1;
                acc_en = 1'b1; state_d = StY3;
            end
            StY3: begin
                controlS = 3'd5; controlC = 2'd2;
                acc_en = 1'b1; state_d = StOut;
            end
            StOut: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Multiply-accumulate datapath and floor-shift/saturate of the accumulator
    always_comb begin
        prod        = PW'($signed(muxS)) * PW'($signed(muxC));
        preload     = AW'($signed(muxZ)) <<< F;
        acc_sum     = (load ? preload : acc_q) + AW'(prod);
        shifted     = acc_q >>> F;
        shifted_top = shifted[AW-1:N-1];
        // In range only when all bits from the sign bit of the result up are equal
        clamp       = !((&shifted_top) || !(|shifted_top));
        if (clamp) begin
            res = shifted[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            res = shifted[N-1:0];
        end
    end

    // State, accumulator, delay line and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            fk_q       <= '0;
            fk1_q      <= '0;
            fk2_q      <= '0;
            yk_q       <= '0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            if (acc_en) acc_q <= acc_sum;
            if (state_q == StFs) begin
                fk_q <= res;
                if (clamp) sat_flag_q <= 1'b1;
            end
            if (state_q == StOut) begin
                yk_q       <= res;
                fk2_q      <= fk1_q;
                fk1_q      <= fk_q;
                done_q     <= 1'b1;
                sat_q      <= sat_flag_q | clamp;
                sat_flag_q <= 1'b0;
            end
        end
    end

    assign fk   = fk_q;
    assign fk1  = fk1_q;
    assign fk2  = fk2_q;
    assign yk   = yk_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign sat  = sat_q;

endmodule

// File: tb/tb_biquad_sequencer.sv
// Self-checking bench for biquad_sequencer: a behavioural mux plus a sample-level
// reference model of the biquad recurrence with clamping.
module tb_biquad_sequencer;

    localparam int N = 16;
    localparam int F = 14;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [N-1:0] muxS, muxC, muxZ;
    logic [2:0]   controlS;
    logic [1:0]   controlC, controlZ;
    logic [N-1:0] fk, fk1, fk2, yk;
    logic         busy, done, sat;

    int n_checks = 0;
    int n_fail   = 0;

    // Mux constants and the Uk presented to the mux
    int a1, a2, b0, b1, b2, uk_v;

    // Reference model state
    int m_fk, m_fk1, m_fk2, m_yk;
    bit m_sat;

    int exp_s[7] = '{1, 2, 0, 3, 4, 5, 0};
    int exp_c[7] = '{1, 2, 0, 3, 1, 2, 0};
    int exp_z[7] = '{1, 0, 0, 0, 0, 0, 0};

    biquad_sequencer #(.N(N), .F(F)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .muxS     (muxS),
        .muxC     (muxC),
        .muxZ     (muxZ),
        .controlS (controlS),
        .controlC (controlC),
        .controlZ (controlZ),
        .fk       (fk),
        .fk1      (fk1),
        .fk2      (fk2),
        .yk       (yk),
        .busy     (busy),
        .done     (done),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    // Behavioural selector mux
    always_comb begin
        muxS = '0;
        muxC = '0;
        muxZ = '0;
        case (controlS)
            3'd1: muxS = N'(a1);
            3'd2: muxS = N'(a2);
            3'd3: muxS = N'(b0);
            3'd4: muxS = N'(b1);
            3'd5: muxS = N'(b2);
            default: muxS = '0;
        endcase
        case (controlC)
            2'd1: muxC = fk1;
            2'd2: muxC = fk2;
            2'd3: muxC = fk;
            default: muxC = '0;
        endcase
        case (controlZ)
            2'd1: muxZ = N'(uk_v);
            2'd2: muxZ = yk;
            default: muxZ = '0;
        endcase
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input longint v, output bit c);
        longint hi = (64'sd1 <<< (N - 1)) - 1;
        longint lo = -(64'sd1 <<< (N - 1));
        c = 1'b0;
        if (v > hi) begin
            c = 1'b1;
            return int'(hi);
        end
        if (v < lo) begin
            c = 1'b1;
            return int'(lo);
        end
        return int'(v);
    endfunction

    // One sample of the recurrence, updating the model delay line
    task automatic model_step(input int uk);
        longint acc;
        bit c1, c2;
        acc = (longint'(uk) <<< F) + longint'(a1) * m_fk1 + longint'(a2) * m_fk2;
        m_fk = clampi(acc >>> F, c1);
        acc = longint'(b0) * m_fk + longint'(b1) * m_fk1 + longint'(b2) * m_fk2;
        m_yk = clampi(acc >>> F, c2);
        m_sat = c1 | c2;
        m_fk2 = m_fk1;
        m_fk1 = m_fk;
    endtask

    task automatic model_reset();
        m_fk = 0; m_fk1 = 0; m_fk2 = 0; m_yk = 0; m_sat = 1'b0;
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after E7
    task automatic do_sample(input int uk, input bit mid_start);
        uk_v  = uk;
        start = 1'b1;
        model_step(uk);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("controlS", controlS, exp_s[i]);
            check("controlC", controlC, exp_c[i]);
            check("controlZ", controlZ, exp_z[i]);
            check("busy", busy, 1);
            check("done_early", done, 0);
            if (i == 3) check("fk_mid", $signed(fk), m_fk);
            start = (mid_start && i == 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done", done, 1);
        check("sat", sat, m_sat);
        check("yk", $signed(yk), m_yk);
        check("fk", $signed(fk), m_fk);
        check("fk1", $signed(fk1), m_fk1);
        check("fk2", $signed(fk2), m_fk2);
        check("busy_end", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        a1 = 32702; a2 = -16318; b0 = 16351; b1 = -32702; b2 = 16351;
        uk_v = 0;
        reset = 1'b1;
        start = 1'b0;
        model_reset();

        // Reset held 3 cycles with start toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = ~start;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat", sat, 0);
        check("rst_yk", yk, 0);
        check("rst_fk", fk, 0);
        check("rst_fk1", fk1, 0);
        check("rst_fk2", fk2, 0);
        check("rst_sel", {controlS, controlC, controlZ}, 0);
        @(posedge clk); #1;
        check("rst_idle", busy, 0);

        // Impulse response; second sample also pulses start mid-sample
        do_sample(16384, 1'b0);
        check("imp0_fk", $signed(fk), 16384);
        check("imp0_yk", $signed(yk), 16351);
        do_sample(0, 1'b1);
        check("imp1_fk", $signed(fk), 32702);
        check("imp1_yk", $signed(yk), -66);
        check("imp1_fk1", $signed(fk1), 32702);
        check("imp1_fk2", $signed(fk2), 16384);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("mid_start_ignored", busy, 0);

        // Saturation from a clean state
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        do_sample(32767, 1'b0);
        check("sat0_sat", sat, 0);
        do_sample(32767, 1'b0);
        check("sat1_fk", $signed(fk), 32767);
        check("sat1_sat", sat, 1);
        @(posedge clk); #1;
        check("sat_cleared", sat, 0);

        // Reset during Y2 discards the partial sample
        uk_v  = 12345;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("y2_sel", controlS, 4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_fk", fk, 0);
        check("mrst_fk1", fk1, 0);
        check("mrst_fk2", fk2, 0);
        check("mrst_yk", yk, 0);
        repeat (8) begin
            @(posedge clk); #1;
            check("mrst_no_done", done, 0);
        end
        do_sample(16384, 1'b0);
        check("mrst_imp_yk", $signed(yk), 16351);

        // Back-to-back: each start presented in the first idle cycle
        for (int i = 0; i < 4; i++) do_sample(int'($urandom_range(0, 8192)) - 4096, 1'b0);

        // Randomized coefficients, inputs and idle gaps
        for (int t = 0; t < 3; t++) begin
            a1 = int'($signed(16'($urandom)));
            a2 = int'($signed(16'($urandom)));
            b0 = int'($signed(16'($urandom)));
            b1 = int'($signed(16'($urandom)));
            b2 = int'($signed(16'($urandom)));
            for (int i = 0; i < 8; i++) begin
                do_sample(int'($signed(16'($urandom))), 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                    check("gap_idle", busy, 0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
